data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem_if.sv | 38 +++
 rtl/data_mem.sv | 168 ++++++++++++++++
 tb/tb_data_mem.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Request/response bundle between the pipeline's memory stage and data_mem.
// The master drives one load or store request per cycle. The slave returns the
// registered load result, its ready level and a one-cycle reject pulse.
interface data_mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] mem_data;
    logic        ready;
    logic        err;

    modport master (
        output mem_read,
        output mem_write,
        output addr,
        output write_data,
        output size,
        output load_unsigned,
        input  mem_data,
        input  ready,
        input  err
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  addr,
        input  write_data,
        input  size,
        input  load_unsigned,
        output mem_data,
        output ready,
        output err
    );
endinterface

// File: rtl/data_mem.sv
// Word-organised data memory with byte/halfword/word access and little-endian lanes.
// After reset, an INIT sweep zeroes every word before any request is accepted.
// Loads have one cycle of latency into a registered mem_data. Misaligned,
// reserved-size or ambiguous requests are dropped and flagged on err one cycle later.
module data_mem #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input logic     clk,
    input logic     rst,
    data_mem_if.slave bus
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH_WORDS - 1);

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   count_q;
    logic              ready_q;
    logic              err_q;
    logic [31:0]       mem_data_q;

    logic [3:0][7:0]   mem_q [DEPTH_WORDS];

    logic [IdxW-1:0]   idx;
    logic              bad_req;
    logic              accept;
    logic              reject;
    logic              store_en;
    logic              load_en;
    logic [3:0]        be;
    logic [3:0][7:0]   wdata;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;

    // Address bits above the word index only alias, so they are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^bus.addr[31:IdxW+2];

    assign idx = bus.addr[IdxW+1:2];

    // Classify the current request: legal accept, reject, or nothing.
    always_comb begin
        bad_req = 1'b0;
        if (bus.mem_read && bus.mem_write) begin
            bad_req = 1'b1;
        end
        if (bus.size == 2'd3) begin
            bad_req = 1'b1;
        end
        if (bus.size == 2'd1 && bus.addr[0]) begin
            bad_req = 1'b1;
        end
        if (bus.size == 2'd2 && bus.addr[1:0] != 2'b00) begin
            bad_req = 1'b1;
        end
        // Requests seen while not ready are ignored entirely, including their error.
        accept   = ready_q && (bus.mem_read ^ bus.mem_write) && !bad_req;
        reject   = ready_q && (bus.mem_read || bus.mem_write) && bad_req;
        store_en = accept && bus.mem_write;
        load_en  = accept && bus.mem_read;
    end

    // Build lane enables and lane-replicated store data from size and low address bits.
    always_comb begin
        be    = 4'b0000;
        wdata = bus.write_data;
        case (bus.size)
            2'd0: begin
                be    = 4'b0001 << bus.addr[1:0];
                wdata = {4{bus.write_data[7:0]}};
            end
            2'd1: begin
                be    = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.write_data[15:0]}};
            end
            2'd2: begin
                be    = 4'b1111;
                wdata = bus.write_data;
            end
            default: begin
                be    = 4'b0000;
                wdata = bus.write_data;
            end
        endcase
    end

    // Pick the addressed lane out of the stored word and extend it to 32 bits.
    always_comb begin
        rd_word  = mem_q[idx];
        rd_byte  = rd_word[{bus.addr[1:0], 3'b000} +: 8];
        rd_half  = bus.addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (bus.size)
            2'd0: begin
                load_val = bus.load_unsigned ? {24'b0, rd_byte}
                                             : {{24{rd_byte[7]}}, rd_byte};
            end
            2'd1: begin
                load_val = bus.load_unsigned ? {16'b0, rd_half}
                                             : {{16{rd_half[15]}}, rd_half};
            end
            default: begin
                load_val = rd_word;
            end
        endcase
    end

    // Storage write port: the INIT sweep clears one word per cycle, RUN applies lane stores.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StInit) begin
                mem_q[count_q] <= '0;
            end else if (store_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[idx][b] <= wdata[b];
                    end
                end
            end
        end
    end

    // Control FSM with registered ready, err and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            count_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            mem_data_q <= '0;
        end else begin
            err_q <= reject;
            if (load_en) begin
                mem_data_q <= load_val;
            end
            case (state_q)
                StInit: begin
                    ready_q <= 1'b0;
                    count_q <= count_q + IdxW'(1);
                    if (count_q == LastIdx) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StInit;
                    count_q <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_data = mem_data_q;
    assign bus.ready    = ready_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: init sweep timing, lane stores and loads,
// rejects, aliasing, and reset behaviour in both states.
module tb_data_mem;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;

    data_mem_if bus ();

    data_mem #(
        .DEPTH_WORDS (256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.addr       = 32'h0;
        bus.write_data = 32'h0;
        bus.size       = 2'd2;
        bus.load_unsigned = 1'b0;
    endtask

    // One request cycle; afterwards the strobes drop and the outputs reflect the edge.
    task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic uns);
        bus.mem_read      = rd;
        bus.mem_write     = wr;
        bus.addr          = a;
        bus.write_data    = wd;
        bus.size          = sz;
        bus.load_unsigned = uns;
        step();
        idle();
    endtask

    // Counts cycles until ready rises; a store pulse can be injected at a chosen cycle.
    task automatic wait_ready(input int inject_at, output int n);
        logic err_seen;
        err_seen = 1'b0;
        n = 0;
        while (!bus.ready && n < 2000) begin
            if (n == inject_at) begin
                bus.mem_write  = 1'b1;
                bus.addr       = 32'h0;
                bus.write_data = 32'hDEADBEEF;
                bus.size       = 2'd2;
            end
            step();
            idle();
            if (bus.err) err_seen = 1'b1;
            n++;
        end
        check("init_err_quiet", {31'b0, err_seen}, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();

        // Reset state and init sweep length.
        rst = 1'b1;
        step();
        check("rst_ready", {31'b0, bus.ready}, 32'h0);
        check("rst_err", {31'b0, bus.err}, 32'h0);
        check("rst_mem_data", bus.mem_data, 32'h0);
        rst = 1'b0;
        wait_ready(-1, cyc);
        check("init_cycles", cyc, 256);
        req(1, 0, 32'h3FC, 0, 2'd2, 0);
        check("lw_3fc_zero", bus.mem_data, 32'h0);

        // Byte and halfword extraction with sign/zero extension.
        req(0, 1, 32'h10, 32'h80FF7F01, 2'd2, 0);
        check("sw_no_err", {31'b0, bus.err}, 32'h0);
        req(1, 0, 32'h10, 0, 2'd0, 0);
        check("lb_10", bus.mem_data, 32'h00000001);
        req(1, 0, 32'h11, 0, 2'd0, 0);
        check("lb_11", bus.mem_data, 32'h0000007F);
        req(1, 0, 32'h12, 0, 2'd0, 0);
        check("lb_12", bus.mem_data, 32'hFFFFFFFF);
        req(1, 0, 32'h13, 0, 2'd0, 1);
        check("lbu_13", bus.mem_data, 32'h00000080);
        req(1, 0, 32'h13, 0, 2'd0, 0);
        check("lb_13", bus.mem_data, 32'hFFFFFF80);
        req(1, 0, 32'h12, 0, 2'd1, 0);
        check("lh_12", bus.mem_data, 32'hFFFF80FF);
        req(1, 0, 32'h12, 0, 2'd1, 1);
        check("lhu_12", bus.mem_data, 32'h000080FF);
        req(1, 0, 32'h10, 0, 2'd1, 0);
        check("lh_10", bus.mem_data, 32'h00007F01);
        req(1, 0, 32'h10, 0, 2'd2, 1);
        check("lw_ignores_uns", bus.mem_data, 32'h80FF7F01);

        // Partial stores only touch their lanes; store leaves mem_data alone.
        req(0, 1, 32'h20, 32'hAABBCCDD, 2'd2, 0);
        check("store_holds_data", bus.mem_data, 32'h80FF7F01);
        req(0, 1, 32'h21, 32'hFFFFFF11, 2'd0, 0);
        req(0, 1, 32'h22, 32'hEEEE2233, 2'd1, 0);
        req(1, 0, 32'h20, 0, 2'd2, 0);
        check("lw_20_merged", bus.mem_data, 32'h223311DD);

        // Rejections: err pulses, no memory change, mem_data held.
        req(0, 1, 32'h30, 32'hCAFEF00D, 2'd2, 0);
        req(1, 0, 32'h30, 0, 2'd2, 0);
        check("lw_30", bus.mem_data, 32'hCAFEF00D);
        req(1, 0, 32'h22, 0, 2'd2, 0);
        check("rej_lw_mis_err", {31'b0, bus.err}, 32'h1);
        check("rej_lw_mis_hold", bus.mem_data, 32'hCAFEF00D);
        req(0, 1, 32'h21, 32'h0000BEEF, 2'd1, 0);
        check("rej_sh_mis_err", {31'b0, bus.err}, 32'h1);
        req(1, 0, 32'h30, 0, 2'd3, 0);
        check("rej_size3_err", {31'b0, bus.err}, 32'h1);
        check("rej_size3_hold", bus.mem_data, 32'hCAFEF00D);
        req(1, 1, 32'h30, 32'h0BADBEEF, 2'd2, 0);
        check("rej_rdwr_err", {31'b0, bus.err}, 32'h1);
        req(0, 1, 32'h31, 32'h0BADBEEF, 2'd2, 0);
        check("rej_sw_mis_err", {31'b0, bus.err}, 32'h1);
        step();
        check("err_clears", {31'b0, bus.err}, 32'h0);
        req(1, 0, 32'h30, 0, 2'd2, 0);
        check("lw_30_intact", bus.mem_data, 32'hCAFEF00D);
        req(1, 0, 32'h20, 0, 2'd2, 0);
        check("lw_20_intact", bus.mem_data, 32'h223311DD);

        // Aliasing above the index bits.
        req(0, 1, 32'h004, 32'h12345678, 2'd2, 0);
        req(1, 0, 32'h404, 0, 2'd2, 0);
        check("alias_404", bus.mem_data, 32'h12345678);
        req(1, 0, 32'hFFFFFC04, 0, 2'd1, 1);
        check("alias_high_lhu", bus.mem_data, 32'h00005678);

        // Reset in RUN with a same-cycle store, then reset again mid-INIT.
        bus.mem_write  = 1'b1;
        bus.addr       = 32'h8;
        bus.write_data = 32'h55AA55AA;
        bus.size       = 2'd2;
        rst = 1'b1;
        step();
        idle();
        check("run_rst_ready", {31'b0, bus.ready}, 32'h0);
        check("run_rst_data", bus.mem_data, 32'h0);
        rst = 1'b0;
        repeat (100) step();
        check("mid_init_ready", {31'b0, bus.ready}, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(10, cyc);
        check("reinit_cycles", cyc, 256);
        check("reinit_data", bus.mem_data, 32'h0);
        req(1, 0, 32'h0, 0, 2'd2, 0);
        check("init_store_ignored", bus.mem_data, 32'h0);
        req(1, 0, 32'h8, 0, 2'd2, 0);
        check("lw_8_cleared", bus.mem_data, 32'h0);
        req(1, 0, 32'h30, 0, 2'd2, 0);
        check("lw_30_cleared", bus.mem_data, 32'h0);
        req(1, 0, 32'h4, 0, 2'd2, 0);
        check("lw_4_cleared", bus.mem_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
